pipeline_hazard_ctrl: RTL and testbench

- Hazard controller for the 5-stage PipelineCPU datapath (IF, ID, EX, MEM, WB).
- Keeps a shadow copy of the pipeline's register-use info in its own pipeline registers for EX, MEM and WB.
- From the ID-stage decode it produces:
  - stall controls: PC write, IF/ID write, ID/EX bubble;
  - forwarding selects for the two EX-stage ALU operands.
- Sits beside the Control unit. Its outputs gate PipelineCPU's PC register and the IF_ID/ID_EX pipeline registers, and drive the ALU operand muxes.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_hz_match.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the PipelineCPU hazard controller.
package cpu_pkg;

  // ALU operand source selects driven onto the EX-stage operand muxes.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Architectural $0: hardwired zero, so it never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register-use info the controller shadows for each of EX, MEM and WB.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } hz_entry_t;

  // Operand source choice: MEM holds the newer value, so it beats WB.
  function automatic logic [1:0] fwd_sel(input logic src_used,
                                         input logic mem_hit,
                                         input logic wb_hit);
    if (src_used && mem_hit)     return FWD_EXMEM;
    else if (src_used && wb_hit) return FWD_MEMWB;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hz_match.sv
// Combinational check: does a shadow stage entry write a given register?
module hz_match
  import cpu_pkg::*;
(
  input  hz_entry_t  entry_i,
  input  logic [4:0] reg_i,
  output logic       hit_o
);

  // Only the write-side fields matter here; the source fields are carried
  // through the same struct for other consumers.
  logic unused_src_fields;
  assign unused_src_fields = ^{entry_i.mem_read, entry_i.rs, entry_i.rt,
                               entry_i.use_rs, entry_i.use_rt};

  // Writes to $0 are discarded by the register file, so they never match.
  assign hit_o = entry_i.valid & entry_i.reg_write &
                 (entry_i.dest == reg_i) & (reg_i != REG_ZERO);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage PipelineCPU: stalls IF/ID on unresolved
// dependencies and selects EX-stage operand forwarding.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [4:0]       id_dest,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  hz_entry_t        stage_q [3];
  hz_entry_t        ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [2:0] id_rs_hit, id_rt_hit;   // ID sources vs. EX/MEM/WB writers
  logic [2:1] ex_rs_hit, ex_rt_hit;   // EX sources vs. MEM/WB writers
  logic       hazard;
  logic       stall;

  // ID-stage sources checked against every in-flight writer.
  for (genvar g = 0; g < 3; g++) begin : g_id_match
    hz_match u_rs (.entry_i(stage_q[g]), .reg_i(id_rs), .hit_o(id_rs_hit[g]));
    hz_match u_rt (.entry_i(stage_q[g]), .reg_i(id_rt), .hit_o(id_rt_hit[g]));
  end

  // EX-stage sources checked against the two younger-result stages.
  for (genvar g = MEM; g <= WB; g++) begin : g_ex_match
    hz_match u_rs (.entry_i(stage_q[g]), .reg_i(stage_q[EX].rs), .hit_o(ex_rs_hit[g]));
    hz_match u_rt (.entry_i(stage_q[g]), .reg_i(stage_q[EX].rt), .hit_o(ex_rt_hit[g]));
  end

  // Hazard detection: with forwarding only a load in EX is unresolvable;
  // without it any writer still ahead of WB's end-of-cycle RF write is.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hazard = 1'b0;
    if (FORWARD) begin
      hazard = stage_q[EX].mem_read &
               ((id_use_rs & id_rs_hit[EX]) | (id_use_rt & id_rt_hit[EX]));
    end else begin
      hazard = (id_use_rs & (|id_rs_hit)) | (id_use_rt & (|id_rt_hit));
    end
    if (!id_valid) hazard = 1'b0;
  end

  assign stall       = hazard;
  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;

  // Operand forwarding for the instruction currently in EX.
  assign fwd_a = FORWARD ? fwd_sel(stage_q[EX].use_rs, ex_rs_hit[MEM], ex_rs_hit[WB]) : FWD_RF;
  assign fwd_b = FORWARD ? fwd_sel(stage_q[EX].use_rt, ex_rt_hit[MEM], ex_rt_hit[WB]) : FWD_RF;

  // Next EX entry (bubble on stall) and saturating stall counter.
  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.dest      = id_dest;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.use_rs    = id_use_rs;
      ex_d.use_rt    = id_use_rt;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Shadow pipeline advances every cycle; reset abandons any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow stages are reset explicitly; stale valid bits after
      // reset would raise phantom hazards against the first instructions.
      for (int i = 0; i < 3; i++) stage_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let WB<=MEM<=EX<=ID shift in one edge
      // regardless of statement order.
      stage_q[WB]  <= stage_q[MEM];
      stage_q[MEM] <= stage_q[EX];
      stage_q[EX]  <= ex_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: FORWARD=1 instance driven from a per-cycle vector table,
// FORWARD=0 instance driven by hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, rw, mr;
    logic [4:0] dest;
    logic       e_stall;
    logic [1:0] e_fa, e_fb;
    int         e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_reg_write = 0, id_mem_read = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dest = 0;

  logic        f1_pc_write, f1_ifid_write, f1_idex_bubble;
  logic [1:0]  f1_fwd_a, f1_fwd_b;
  logic [15:0] f1_stall_cnt;
  logic        f0_pc_write, f0_ifid_write, f0_idex_bubble;
  logic [1:0]  f0_fwd_a, f0_fwd_b;
  logic [2:0]  f0_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FORWARD(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .pc_write(f1_pc_write),
    .ifid_write(f1_ifid_write), .idex_bubble(f1_idex_bubble), .fwd_a(f1_fwd_a),
    .fwd_b(f1_fwd_b), .stall_cnt(f1_stall_cnt));

  pipeline_hazard_ctrl #(.FORWARD(1'b0), .CNT_W(3)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .pc_write(f0_pc_write),
    .ifid_write(f0_ifid_write), .idex_bubble(f0_idex_bubble), .fwd_a(f0_fwd_a),
    .fwd_b(f0_fwd_b), .stall_cnt(f0_stall_cnt));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic rw,
                              input logic mr, input logic [4:0] dest, input logic s,
                              input logic [1:0] fa, input logic [1:0] fb, input int cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rw = rw; r.mr = mr;
    r.dest = dest; r.e_stall = s; r.e_fa = fa; r.e_fb = fb; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs; id_use_rt = x.urt;
    id_reg_write = x.rw; id_mem_read = x.mr; id_dest = x.dest;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // FORWARD=0: producer of $7, 'gap' independent instructions, then a reader
  // of $7 held in ID until the stall clears.
  task automatic f0_pair(input int gap, input int exp_stalls, input string name);
    int stalls = 0;
    int bad    = 0;
    drive(mk(1, 1, 2, 1, 1, 1, 0, 7, 0, 0, 0, 0));             // add $7,$1,$2
    step();
    for (int i = 0; i < gap; i++) begin
      drive(mk(1, 21, 22, 1, 1, 1, 0, 20, 0, 0, 0, 0));        // add $20,$21,$22
      step();
    end
    drive(mk(1, 7, 0, 1, 1, 1, 0, 8, 0, 0, 0, 0));             // add $8,$7,$0
    #1;
    while (f0_idex_bubble === 1'b1 && stalls < 8) begin
      if (f0_pc_write !== 1'b0 || f0_ifid_write !== 1'b0) bad++;
      stalls++;
      step();
    end
    check({name, "_stalls"}, stalls, exp_stalls);
    check({name, "_pc_ifid_hold"}, bad, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check({name, "_fwd_a_const"}, int'(f0_fwd_a), 0);
  endtask

  vec_t tbl [21];

  initial begin
    // Row = one ID cycle: inputs, then expected stall / fwd_a / fwd_b / count.
    tbl[0]  = mk(1, 1, 2, 1, 0, 1, 1, 2, 0, 2'b00, 2'b00, 0); // lw  $2,0($1)
    tbl[1]  = mk(1, 2, 4, 1, 1, 1, 0, 3, 1, 2'b00, 2'b00, 0); // add $3,$2,$4 (stall)
    tbl[2]  = mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 2'b00, 2'b00, 1); // add held, bubble in EX
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1); // add in EX, lw in WB
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    tbl[6]  = mk(1, 2, 3, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1); // add $1,$2,$3
    tbl[7]  = mk(1, 1, 1, 1, 1, 1, 0, 4, 0, 2'b00, 2'b00, 1); // sub $4,$1,$1
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1); // sub in EX, add in MEM
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    tbl[10] = mk(1, 2, 3, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1); // add $1,$2,$3
    tbl[11] = mk(1, 6, 7, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1); // add $1,$6,$7
    tbl[12] = mk(1, 1, 0, 1, 1, 1, 0, 5, 0, 2'b00, 2'b00, 1); // or  $5,$1,$0
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1); // MEM beats WB; $0 never
    tbl[14] = mk(1, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw  $0,0($1)
    tbl[15] = mk(1, 0, 0, 1, 1, 1, 0, 3, 0, 2'b00, 2'b00, 1); // add $3,$0,$0 (no stall)
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    tbl[17] = mk(1, 0, 8, 1, 0, 1, 1, 8, 0, 2'b00, 2'b00, 1); // lw  $8,0($0)
    tbl[18] = mk(1, 0, 8, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1); // sw  $8,0($0) (stall)
    tbl[19] = mk(1, 0, 8, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2); // sw held
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2); // sw in EX, lw in WB

    // Reset state of both instances, before any clock edge.
    #1;
    check("rst_f1_pc_write", int'(f1_pc_write), 1);
    check("rst_f1_ifid_write", int'(f1_ifid_write), 1);
    check("rst_f1_idex_bubble", int'(f1_idex_bubble), 0);
    check("rst_f1_fwd", int'({f1_fwd_a, f1_fwd_b}), 0);
    check("rst_f1_stall_cnt", int'(f1_stall_cnt), 0);
    check("rst_f0_pc_write", int'(f0_pc_write), 1);
    check("rst_f0_stall_cnt", int'(f0_stall_cnt), 0);

    // FORWARD=1 vector table.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d_pc_write", i), int'(f1_pc_write), int'(!tbl[i].e_stall));
      check($sformatf("v%0d_ifid_write", i), int'(f1_ifid_write), int'(!tbl[i].e_stall));
      check($sformatf("v%0d_idex_bubble", i), int'(f1_idex_bubble), int'(tbl[i].e_stall));
      check($sformatf("v%0d_fwd_a", i), int'(f1_fwd_a), int'(tbl[i].e_fa));
      check($sformatf("v%0d_fwd_b", i), int'(f1_fwd_b), int'(tbl[i].e_fb));
      check($sformatf("v%0d_stall_cnt", i), int'(f1_stall_cnt), tbl[i].e_cnt);
      step();
    end

    // FORWARD=0 stall latencies and counter saturation (3-bit counter).
    do_reset();
    f0_pair(0, 3, "f0_gap0");
    check("f0_cnt_after_gap0", int'(f0_stall_cnt), 3);
    f0_pair(1, 2, "f0_gap1");
    check("f0_cnt_after_gap1", int'(f0_stall_cnt), 5);
    f0_pair(2, 1, "f0_gap2");
    check("f0_cnt_after_gap2", int'(f0_stall_cnt), 6);
    f0_pair(0, 3, "f0_sat");
    check("f0_cnt_saturated", int'(f0_stall_cnt), 7);

    // Asynchronous reset in the 2nd cycle of a FORWARD=0 stall.
    do_reset();
    drive(mk(1, 1, 2, 1, 1, 1, 0, 7, 0, 0, 0, 0));             // add $7,$1,$2
    step();
    drive(mk(1, 7, 0, 1, 1, 1, 0, 8, 0, 0, 0, 0));             // add $8,$7,$0
    #1;
    check("mid_stall_1st", int'(f0_idex_bubble), 1);
    step();
    check("mid_stall_2nd", int'(f0_idex_bubble), 1);
    check("mid_stall_cnt", int'(f0_stall_cnt), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc_write", int'(f0_pc_write), 1);
    check("async_rst_ifid_write", int'(f0_ifid_write), 1);
    check("async_rst_idex_bubble", int'(f0_idex_bubble), 0);
    check("async_rst_fwd", int'({f0_fwd_a, f0_fwd_b}), 0);
    check("async_rst_stall_cnt", int'(f0_stall_cnt), 0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_no_stall", int'(f0_idex_bubble), 0);
    check("post_rst_pc_write", int'(f0_pc_write), 1);
    step();
    check("post_rst_cnt", int'(f0_stall_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
